// File: rtl/csp_packet_endpoint.sv
// Clocked NoC traffic endpoint: a packet generator and a packet bucket, each
// speaking 4-phase bundled-data req/ack to a router port.
module csp_packet_endpoint #(
    parameter int         WIDTH_packet = 14,
    parameter logic [2:0] SRC_ADDR     = 3'b000,
    parameter logic [2:0] DEST_ADDR    = 3'b001,
    parameter int         NODE         = 0,
    parameter int         NUM_PACKETS  = 2,
    parameter int         FL           = 2,
    parameter int         BL           = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    gen_en,
    output logic                    gen_done,
    output logic                    out_req,
    input  logic                    out_ack,
    output logic [WIDTH_packet-1:0] out_data,
    input  logic                    in_req,
    output logic                    in_ack,
    input  logic [WIDTH_packet-1:0] in_data,
    output logic                    rx_valid,
    output logic [WIDTH_packet-1:0] rx_data,
    output logic [15:0]             rx_count,
    output logic                    rx_misroute
);

    localparam int         FL_CW     = $clog2(FL + 1);
    localparam int         BL_CW     = $clog2(BL + 1);
    localparam logic [2:0] NODE_ADDR = 3'(NODE);
    localparam logic [7:0] LAST_IDX  = 8'(NUM_PACKETS - 1);

    function automatic logic [WIDTH_packet-1:0] make_pkt(input logic [7:0] idx);
        make_pkt       = '0;
        make_pkt[13:0] = {SRC_ADDR, idx, DEST_ADDR};
    endfunction

    typedef enum logic [2:0] {G_IDLE, G_SETUP, G_REQ_HI, G_REQ_LO, G_DONE} gen_state_t;
    typedef enum logic [1:0] {B_WAIT_REQ, B_DELAY, B_ACK_HI} bkt_state_t;

    gen_state_t               r_gen_state, w_gen_next;
    logic [FL_CW-1:0]         r_fl_cnt;
    logic [7:0]               r_pkt_idx;
    logic [WIDTH_packet-1:0]  r_out_data;
    logic                     w_fl_expired;
    logic                     w_more;

    assign w_fl_expired = (r_fl_cnt == FL_CW'(FL - 1));
    assign w_more       = (r_pkt_idx != LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_gen_state <= G_IDLE;
        else        r_gen_state <= w_gen_next;
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        w_gen_next = r_gen_state;
        case (r_gen_state)
            G_IDLE:   if (gen_en)       w_gen_next = G_SETUP;
            G_SETUP:  if (w_fl_expired) w_gen_next = G_REQ_HI;
            G_REQ_HI: if (out_ack)      w_gen_next = G_REQ_LO;
            G_REQ_LO: if (!out_ack)     w_gen_next = w_more ? G_SETUP : G_DONE;
            G_DONE:                     w_gen_next = G_DONE;
            default:                    w_gen_next = G_IDLE;
        endcase
    end

    always_comb begin
        out_req  = (r_gen_state == G_REQ_HI);
        gen_done = (r_gen_state == G_DONE);
    end

    // A load restarts the forward-latency count; out_data is otherwise frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fl_cnt   <= '0;
            r_pkt_idx  <= '0;
            r_out_data <= '0;
        end else if (r_gen_state == G_IDLE && gen_en) begin
            r_fl_cnt   <= '0;
            r_pkt_idx  <= '0;
            r_out_data <= make_pkt(8'd0);
        end else if (r_gen_state == G_REQ_LO && !out_ack && w_more) begin
            r_fl_cnt   <= '0;
            r_pkt_idx  <= r_pkt_idx + 8'd1;
            r_out_data <= make_pkt(r_pkt_idx + 8'd1);
        end else if (r_gen_state == G_SETUP) begin
            r_fl_cnt   <= r_fl_cnt + 1'b1;
        end
    end

    assign out_data = r_out_data;

    bkt_state_t              r_bkt_state, w_bkt_next;
    logic [BL_CW-1:0]        r_bl_cnt;
    logic                    w_bl_expired;
    logic                    w_capture;
    logic                    r_rx_valid;
    logic [WIDTH_packet-1:0] r_rx_data;
    logic [15:0]             r_rx_count;
    logic                    r_rx_misroute;

    assign w_bl_expired = (r_bl_cnt == BL_CW'(BL - 1));
    assign w_capture    = (r_bkt_state != B_ACK_HI) && (w_bkt_next == B_ACK_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_bkt_state <= B_WAIT_REQ;
        else        r_bkt_state <= w_bkt_next;
    end

    // With BL=1 the acknowledge is raised on the edge that first samples req.
    always_comb begin
        w_bkt_next = r_bkt_state;
        case (r_bkt_state)
            B_WAIT_REQ: if (in_req)       w_bkt_next = (BL == 1) ? B_ACK_HI : B_DELAY;
            B_DELAY:    if (w_bl_expired) w_bkt_next = B_ACK_HI;
            B_ACK_HI:   if (!in_req)      w_bkt_next = B_WAIT_REQ;
            default:                      w_bkt_next = B_WAIT_REQ;
        endcase
    end

    always_comb begin
        in_ack = (r_bkt_state == B_ACK_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bl_cnt      <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_data     <= '0;
            r_rx_count    <= '0;
            r_rx_misroute <= 1'b0;
        end else begin
            r_rx_valid <= w_capture;
            if (r_bkt_state == B_WAIT_REQ) r_bl_cnt <= BL_CW'(1);
            else if (r_bkt_state == B_DELAY) r_bl_cnt <= r_bl_cnt + 1'b1;
            if (w_capture) begin
                r_rx_data <= in_data;
                if (r_rx_count != 16'hFFFF) r_rx_count <= r_rx_count + 16'd1;
                if (in_data[2:0] != NODE_ADDR) r_rx_misroute <= 1'b1;
            end
        end
    end

    assign rx_valid    = r_rx_valid;
    assign rx_data     = r_rx_data;
    assign rx_count    = r_rx_count;
    assign rx_misroute = r_rx_misroute;

endmodule

// File: tb/tb_csp_packet_endpoint.sv
// Directed bench for csp_packet_endpoint: bucket vector table, generator
// slow-peer and reset sequences, and loopback runs on three configurations.
module tb_csp_packet_endpoint;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A: defaults, NODE=1, bench can drive both channels or loop back.
    logic        rst_n_a = 1'b0, a_gen_en = 1'b0, a_lb = 1'b0;
    logic        a_tb_in_req = 1'b0, a_tb_out_ack = 1'b0;
    logic [13:0] a_tb_in_data = '0;
    logic        a_gen_done, a_out_req, a_out_ack, a_in_req, a_in_ack, a_rx_valid, a_rx_misroute;
    logic [13:0] a_out_data, a_in_data, a_rx_data;
    logic [15:0] a_rx_count;

    assign a_in_req  = a_lb ? a_out_req  : a_tb_in_req;
    assign a_in_data = a_lb ? a_out_data : a_tb_in_data;
    assign a_out_ack = a_lb ? a_in_ack   : a_tb_out_ack;

    csp_packet_endpoint #(.NODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .gen_en(a_gen_en), .gen_done(a_gen_done),
        .out_req(a_out_req), .out_ack(a_out_ack), .out_data(a_out_data),
        .in_req(a_in_req), .in_ack(a_in_ack), .in_data(a_in_data),
        .rx_valid(a_rx_valid), .rx_data(a_rx_data), .rx_count(a_rx_count),
        .rx_misroute(a_rx_misroute)
    );

    // Instance B: misrouted loopback (dest 2 delivered to node 0).
    logic        rst_n_b = 1'b0, b_gen_en = 1'b0;
    logic        b_gen_done, b_out_req, b_in_ack, b_rx_valid, b_rx_misroute;
    logic [13:0] b_out_data, b_rx_data;
    logic [15:0] b_rx_count;

    csp_packet_endpoint #(.NODE(0), .DEST_ADDR(3'b010)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .gen_en(b_gen_en), .gen_done(b_gen_done),
        .out_req(b_out_req), .out_ack(b_in_ack), .out_data(b_out_data),
        .in_req(b_out_req), .in_ack(b_in_ack), .in_data(b_out_data),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data), .rx_count(b_rx_count),
        .rx_misroute(b_rx_misroute)
    );

    // Instance C: long loopback run of 255 packets.
    logic        rst_n_c = 1'b0, c_gen_en = 1'b0;
    logic        c_gen_done, c_out_req, c_in_ack, c_rx_valid, c_rx_misroute;
    logic [13:0] c_out_data, c_rx_data;
    logic [15:0] c_rx_count;

    csp_packet_endpoint #(.NODE(1), .NUM_PACKETS(255)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .gen_en(c_gen_en), .gen_done(c_gen_done),
        .out_req(c_out_req), .out_ack(c_in_ack), .out_data(c_out_data),
        .in_req(c_out_req), .in_ack(c_in_ack), .in_data(c_out_data),
        .rx_valid(c_rx_valid), .rx_data(c_rx_data), .rx_count(c_rx_count),
        .rx_misroute(c_rx_misroute)
    );

    typedef struct {
        logic        req;
        logic [13:0] data;
        logic        ack;
        logic        valid;
        logic [13:0] rx;
        logic [15:0] cnt;
        logic        mis;
    } bvec_t;

    bvec_t vecs[10];

    task automatic check_a_all_zero(input string tag);
        check({tag, " out_req"},     32'(a_out_req),     32'd0);
        check({tag, " out_data"},    32'(a_out_data),    32'd0);
        check({tag, " gen_done"},    32'(a_gen_done),    32'd0);
        check({tag, " in_ack"},      32'(a_in_ack),      32'd0);
        check({tag, " rx_valid"},    32'(a_rx_valid),    32'd0);
        check({tag, " rx_data"},     32'(a_rx_data),     32'd0);
        check({tag, " rx_count"},    32'(a_rx_count),    32'd0);
        check({tag, " rx_misroute"}, 32'(a_rx_misroute), 32'd0);
    endtask

    initial begin
        logic [13:0] rx_seen[$];
        int          rx_cyc[$];
        int          n_rx;
        logic        first_mis;
        logic [7:0]  k;
        logic [13:0] exp_pkt;

        // Bucket on instance A, BL=1, NODE=1; starts after one packet already received.
        vecs[0] = '{1'b1, 14'b00001001000001, 1'b1, 1'b1, 14'h0241, 16'd2, 1'b0};
        vecs[1] = '{1'b1, 14'h0241,           1'b1, 1'b0, 14'h0241, 16'd2, 1'b0};
        vecs[2] = '{1'b0, 14'h0241,           1'b0, 1'b0, 14'h0241, 16'd2, 1'b0};
        vecs[3] = '{1'b0, 14'h1234,           1'b0, 1'b0, 14'h0241, 16'd2, 1'b0};
        vecs[4] = '{1'b1, 14'h0005,           1'b1, 1'b1, 14'h0005, 16'd3, 1'b1};
        vecs[5] = '{1'b0, 14'h0005,           1'b0, 1'b0, 14'h0005, 16'd3, 1'b1};
        vecs[6] = '{1'b0, 14'h3FF9,           1'b0, 1'b0, 14'h0005, 16'd3, 1'b1};
        vecs[7] = '{1'b1, 14'h3FF9,           1'b1, 1'b1, 14'h3FF9, 16'd4, 1'b1};
        vecs[8] = '{1'b1, 14'h3FF9,           1'b1, 1'b0, 14'h3FF9, 16'd4, 1'b1};
        vecs[9] = '{1'b0, 14'h3FF9,           1'b0, 1'b0, 14'h3FF9, 16'd4, 1'b1};

        tick();
        tick();
        check_a_all_zero("reset");

        // in_req already high when reset releases counts as a fresh request.
        a_tb_in_req  = 1'b1;
        a_tb_in_data = 14'h0009;
        tick();
        rst_n_a = 1'b1;
        tick();
        check("req_at_release in_ack",   32'(a_in_ack),   32'd1);
        check("req_at_release rx_valid", 32'(a_rx_valid), 32'd1);
        check("req_at_release rx_count", 32'(a_rx_count), 32'd1);
        check("req_at_release rx_data",  32'(a_rx_data),  32'h0009);
        a_tb_in_req = 1'b0;
        tick();
        check("req_at_release ack_fall", 32'(a_in_ack),   32'd0);

        for (int i = 0; i < 10; i++) begin
            a_tb_in_req  = vecs[i].req;
            a_tb_in_data = vecs[i].data;
            tick();
            check($sformatf("vec%0d in_ack", i),      32'(a_in_ack),      32'(vecs[i].ack));
            check($sformatf("vec%0d rx_valid", i),    32'(a_rx_valid),    32'(vecs[i].valid));
            check($sformatf("vec%0d rx_data", i),     32'(a_rx_data),     32'(vecs[i].rx));
            check($sformatf("vec%0d rx_count", i),    32'(a_rx_count),    32'(vecs[i].cnt));
            check($sformatf("vec%0d rx_misroute", i), 32'(a_rx_misroute), 32'(vecs[i].mis));
        end

        // Generator against a slow peer; gen_en dropped mid-run.
        a_gen_en = 1'b1;
        tick();
        check("gen load0 out_data", 32'(a_out_data), 32'h0001);
        check("gen load0 out_req",  32'(a_out_req),  32'd0);
        a_gen_en = 1'b0;
        tick();
        check("gen fl1 out_req", 32'(a_out_req), 32'd0);
        tick();
        check("gen fl2 out_req", 32'(a_out_req), 32'd1);
        a_tb_out_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("slow ack%0d out_req", i),  32'(a_out_req),  32'd0);
            check($sformatf("slow ack%0d out_data", i), 32'(a_out_data), 32'h0001);
        end
        a_tb_out_ack = 1'b0;
        tick();
        check("gen load1 out_data", 32'(a_out_data), 32'h0009);
        check("gen load1 out_req",  32'(a_out_req),  32'd0);
        a_tb_out_ack = 1'b1;
        tick();
        check("ack_in_setup out_req", 32'(a_out_req), 32'd0);
        tick();
        check("ack_in_setup req_rise", 32'(a_out_req), 32'd1);
        tick();
        check("ack_in_setup req_fall", 32'(a_out_req),  32'd0);
        check("gen_done before last",  32'(a_gen_done), 32'd0);
        a_tb_out_ack = 1'b0;
        tick();
        check("gen_done after last", 32'(a_gen_done), 32'd1);
        check("gen final out_data",  32'(a_out_data), 32'h0009);

        // Reset in the middle of a handshake on both channels.
        rst_n_a = 1'b0;
        tick();
        rst_n_a      = 1'b1;
        a_gen_en     = 1'b1;
        a_tb_in_req  = 1'b1;
        a_tb_in_data = 14'h0011;
        tick();
        tick();
        tick();
        check("pre_reset out_req", 32'(a_out_req), 32'd1);
        check("pre_reset in_ack",  32'(a_in_ack),  32'd1);
        #2;
        rst_n_a = 1'b0;
        #1;
        check_a_all_zero("mid_reset");
        a_gen_en    = 1'b0;
        a_tb_in_req = 1'b0;
        tick();
        rst_n_a = 1'b1;
        tick();
        tick();
        check("post_reset out_req",  32'(a_out_req),  32'd0);
        check("post_reset gen_done", 32'(a_gen_done), 32'd0);
        check("post_reset out_data", 32'(a_out_data), 32'd0);

        // Loopback with defaults on instance A.
        rst_n_a = 1'b0;
        a_lb    = 1'b1;
        tick();
        rst_n_a  = 1'b1;
        a_gen_en = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (a_rx_valid) begin
                rx_seen.push_back(a_rx_data);
                rx_cyc.push_back(cyc);
            end
        end
        check("lb packets", 32'(rx_seen.size()), 32'd2);
        if (rx_seen.size() == 2) begin
            check("lb pkt0", 32'(rx_seen[0]), 32'h0001);
            check("lb pkt1", 32'(rx_seen[1]), 32'h0009);
            check("lb spacing", 32'(rx_cyc[1] - rx_cyc[0]), 32'd6);
        end
        check("lb rx_count",    32'(a_rx_count),    32'd2);
        check("lb gen_done",    32'(a_gen_done),    32'd1);
        check("lb rx_misroute", 32'(a_rx_misroute), 32'd0);
        a_gen_en = 1'b0;

        // Misrouted loopback on instance B.
        rst_n_b   = 1'b1;
        b_gen_en  = 1'b1;
        n_rx      = 0;
        first_mis = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (b_rx_valid) begin
                if (n_rx == 0) first_mis = b_rx_misroute;
                n_rx++;
            end
        end
        check("misroute packets",   32'(n_rx),          32'd2);
        check("misroute first",     32'(first_mis),     32'd1);
        check("misroute sticky",    32'(b_rx_misroute), 32'd1);
        check("misroute rx_count",  32'(b_rx_count),    32'd2);
        check("misroute gen_done",  32'(b_gen_done),    32'd1);
        b_gen_en = 1'b0;

        // 255-packet loopback on instance C, payloads checked in order.
        rst_n_c  = 1'b1;
        c_gen_en = 1'b1;
        n_rx     = 0;
        for (int cyc = 0; cyc < 3000 && !c_gen_done; cyc++) begin
            tick();
            if (c_rx_valid) begin
                k       = 8'(n_rx);
                exp_pkt = {3'b000, k, 3'b001};
                check($sformatf("long pkt%0d", n_rx), 32'(c_rx_data), 32'(exp_pkt));
                n_rx++;
            end
        end
        tick();
        check("long gen_done",    32'(c_gen_done),    32'd1);
        check("long packets",     32'(n_rx),          32'd255);
        check("long rx_count",    32'(c_rx_count),    32'd255);
        check("long rx_misroute", 32'(c_rx_misroute), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
